trap_ctrl: RTL and testbench

//  Parametrised trap/interrupt controller, next generation of the PCU trap path.

---
 rtl/trap_pkg.sv | 34 +++
 rtl/trap_csr_file.sv | 129 ++++++++++++
 rtl/trap_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_trap_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
// Shared definitions for the trap controller: CSR map, cause codes, mstatus layout, FSM states.
package trap_pkg;

    localparam logic [11:0] CsrMstatus = 12'h300;
    localparam logic [11:0] CsrMie     = 12'h304;
    localparam logic [11:0] CsrMtvec   = 12'h305;
    localparam logic [11:0] CsrMepc    = 12'h341;
    localparam logic [11:0] CsrMcause  = 12'h342;
    localparam logic [11:0] CsrMtval   = 12'h343;
    localparam logic [11:0] CsrMip     = 12'h344;

    localparam logic [3:0] ExcDiv0   = 4'd1;
    localparam logic [3:0] ExcMem    = 4'd2;
    localparam logic [3:0] ExcDecode = 4'd3;

    localparam int unsigned MstatusMie  = 3;
    localparam int unsigned MstatusMpie = 7;
    localparam int unsigned MstatusDf   = 8;

    localparam int unsigned IrqCauseBase = 16;
    localparam int unsigned IrqIdxW      = 4;

    typedef enum logic [1:0] {
        StIdle,
        StEnter,
        StHandler,
        StReturn
    } trap_state_e;

    function automatic logic [4:0] irq_cause(input logic [IrqIdxW-1:0] idx);
        return 5'(IrqCauseBase) + {1'b0, idx};
    endfunction

endpackage

// File: rtl/trap_csr_file.sv
// Machine trap CSRs: storage, combinational read mux and trap-entry/mret write priority.
module trap_csr_file
    import trap_pkg::*;
#(
    parameter int unsigned             XLEN       = 32,
    parameter int unsigned             N_IRQ      = 8,
    parameter logic [XLEN-1:0]         TVEC_RESET = XLEN'(32'h0000_F000)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              csr_wen_i,
    input  logic [11:0]       csr_wadd_i,
    input  logic [XLEN-1:0]   csr_din_i,
    input  logic [11:0]       csr_radd_i,
    output logic [XLEN-1:0]   csr_dout_o,
    input  logic [N_IRQ-1:0]  mip_i,
    input  logic              entry_i,
    input  logic [XLEN-1:0]   entry_mepc_i,
    input  logic [XLEN-1:0]   entry_mcause_i,
    input  logic [XLEN-1:0]   entry_mtval_i,
    input  logic              mret_i,
    input  logic              df_set_i,
    output logic              mstatus_mie_o,
    output logic [N_IRQ-1:0]  mie_o,
    output logic [XLEN-1:0]   mtvec_o,
    output logic [XLEN-1:0]   mepc_o
);

    logic             mie_bit_q, mie_bit_d;
    logic             mpie_q, mpie_d;
    logic             df_q, df_d;
    logic [N_IRQ-1:0] mie_q, mie_d;
    logic [XLEN-1:0]  mtvec_q, mtvec_d;
    logic [XLEN-1:0]  mepc_q, mepc_d;
    logic [XLEN-1:0]  mcause_q, mcause_d;
    logic [XLEN-1:0]  mtval_q, mtval_d;

    always_comb begin
        mie_bit_d = mie_bit_q;
        mpie_d    = mpie_q;
        df_d      = df_q;
        mie_d     = mie_q;
        mtvec_d   = mtvec_q;
        mepc_d    = mepc_q;
        mcause_d  = mcause_q;
        mtval_d   = mtval_q;

        if (csr_wen_i) begin
            case (csr_wadd_i)
                CsrMstatus: begin
                    mie_bit_d = csr_din_i[MstatusMie];
                    mpie_d    = csr_din_i[MstatusMpie];
                    df_d      = csr_din_i[MstatusDf];
                end
                CsrMie:    mie_d    = csr_din_i[N_IRQ-1:0];
                CsrMtvec:  mtvec_d  = csr_din_i;
                CsrMepc:   mepc_d   = csr_din_i;
                CsrMcause: mcause_d = csr_din_i;
                CsrMtval:  mtval_d  = csr_din_i;
                default:   ;
            endcase
        end

        // Trap entry overrides a same-cycle software write to the trap-state CSRs.
        if (entry_i) begin
            mpie_d    = mie_bit_q;
            mie_bit_d = 1'b0;
            df_d      = df_q;
            mepc_d    = entry_mepc_i;
            mcause_d  = entry_mcause_i;
            mtval_d   = entry_mtval_i;
        end

        if (mret_i) begin
            mie_bit_d = mpie_q;
            mpie_d    = 1'b1;
        end

        if (df_set_i) begin
            df_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mie_bit_q <= 1'b0;
            mpie_q    <= 1'b0;
            df_q      <= 1'b0;
            mie_q     <= '0;
            mtvec_q   <= TVEC_RESET;
            mepc_q    <= '0;
            mcause_q  <= '0;
            mtval_q   <= '0;
        end else begin
            mie_bit_q <= mie_bit_d;
            mpie_q    <= mpie_d;
            df_q      <= df_d;
            mie_q     <= mie_d;
            mtvec_q   <= mtvec_d;
            mepc_q    <= mepc_d;
            mcause_q  <= mcause_d;
            mtval_q   <= mtval_d;
        end
    end

    always_comb begin
        csr_dout_o = '0;
        case (csr_radd_i)
            CsrMstatus: begin
                csr_dout_o[MstatusMie]  = mie_bit_q;
                csr_dout_o[MstatusMpie] = mpie_q;
                csr_dout_o[MstatusDf]   = df_q;
            end
            CsrMie:    csr_dout_o[N_IRQ-1:0] = mie_q;
            CsrMtvec:  csr_dout_o = mtvec_q;
            CsrMepc:   csr_dout_o = mepc_q;
            CsrMcause: csr_dout_o = mcause_q;
            CsrMtval:  csr_dout_o = mtval_q;
            CsrMip:    csr_dout_o[N_IRQ-1:0] = mip_i;
            default:   csr_dout_o = '0;
        endcase
    end

    assign mstatus_mie_o = mie_bit_q;
    assign mie_o         = mie_q;
    assign mtvec_o       = mtvec_q;
    assign mepc_o        = mepc_q;

endmodule

// File: rtl/trap_ctrl.sv
// Trap/interrupt controller: pending latch, priority encoder, trap FSM and PC redirect/flush.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter int unsigned     N_IRQ        = 8,
    parameter logic [XLEN-1:0] TVEC_RESET   = XLEN'(32'h0000_F000),
    parameter int unsigned     FLUSH_CYCLES = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [N_IRQ-1:0]  irq_src_i,
    output logic [N_IRQ-1:0]  irq_ack_o,
    input  logic              exc_valid_i,
    input  logic [3:0]        exc_code_i,
    input  logic [XLEN-1:0]   exc_pc_i,
    input  logic [XLEN-1:0]   exc_tval_i,
    input  logic [XLEN-1:0]   id_pc_i,
    input  logic              mret_i,
    input  logic              csr_wen_i,
    input  logic [11:0]       csr_wadd_i,
    input  logic [XLEN-1:0]   csr_din_i,
    input  logic [11:0]       csr_radd_i,
    output logic [XLEN-1:0]   csr_dout_o,
    output logic [XLEN-1:0]   pc_dout_o,
    output logic              pc_wen_o,
    output logic              npc_mux_sel_o,
    output logic              if_id_clear_o,
    output logic              id_ex_clear_o,
    output logic              ex_mem_clear_o,
    output logic              trap_active_o
);

    localparam int unsigned      CntW     = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CntW-1:0]  FlushMax = CntW'(FLUSH_CYCLES);

    trap_state_e          state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 trap_irq_q, trap_irq_d;
    logic [IrqIdxW-1:0]   trap_idx_q, trap_idx_d;
    logic [N_IRQ-1:0]     irq_smp_q, mip_q, mip_d;
    logic [N_IRQ-1:0]     irq_ack;

    logic                 entry, mret_take, df_set;
    logic [XLEN-1:0]      entry_mepc, entry_mcause, entry_mtval;
    logic                 mstatus_mie;
    logic [N_IRQ-1:0]     mie_reg;
    logic [XLEN-1:0]      mtvec, mepc;
    logic                 irq_hit, take_irq;
    logic [IrqIdxW-1:0]   irq_idx;
    logic [XLEN-1:0]      vec_target;
    logic                 flushing;

    // Edge-triggered pending: a level held high pends once, then is consumed by its ack.
    assign mip_d = (mip_q & ~irq_ack) | (irq_src_i & ~irq_smp_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_smp_q <= '0;
            mip_q     <= '0;
        end else begin
            irq_smp_q <= irq_src_i;
            mip_q     <= mip_d;
        end
    end

    // Downward scan so the lowest enabled pending index is the one left standing.
    always_comb begin
        irq_hit = 1'b0;
        irq_idx = '0;
        for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
            if (mip_q[i] && mie_reg[i]) begin
                irq_hit = 1'b1;
                irq_idx = IrqIdxW'(i);
            end
        end
    end

    assign take_irq = mstatus_mie & irq_hit;

    always_comb begin
        entry_mepc   = exc_valid_i ? exc_pc_i : id_pc_i;
        entry_mtval  = exc_valid_i ? exc_tval_i : '0;
        entry_mcause = '0;
        if (exc_valid_i) begin
            entry_mcause[3:0] = exc_code_i;
        end else begin
            entry_mcause[XLEN-1] = 1'b1;
            entry_mcause[4:0]    = irq_cause(irq_idx);
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        trap_irq_d = trap_irq_q;
        trap_idx_d = trap_idx_q;
        entry      = 1'b0;
        mret_take  = 1'b0;
        df_set     = 1'b0;
        irq_ack    = '0;
        case (state_q)
            StIdle: begin
                if (exc_valid_i) begin
                    entry      = 1'b1;
                    trap_irq_d = 1'b0;
                    state_d    = StEnter;
                    cnt_d      = CntW'(1);
                end else if (take_irq) begin
                    entry      = 1'b1;
                    trap_irq_d = 1'b1;
                    trap_idx_d = irq_idx;
                    irq_ack    = N_IRQ'(1) << irq_idx;
                    state_d    = StEnter;
                    cnt_d      = CntW'(1);
                end
            end
            StEnter: begin
                if (cnt_q >= FlushMax) begin
                    state_d = StHandler;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StHandler: begin
                df_set = exc_valid_i;
                if (mret_i) begin
                    mret_take = 1'b1;
                    state_d   = StReturn;
                    cnt_d     = CntW'(1);
                end
            end
            StReturn: begin
                if (cnt_q >= FlushMax) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            trap_irq_q <= 1'b0;
            trap_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            trap_irq_q <= trap_irq_d;
            trap_idx_q <= trap_idx_d;
        end
    end

    // Vectored mode only offsets interrupts; exceptions always land on the base.
    always_comb begin
        vec_target = mtvec & ~XLEN'(3);
        if (mtvec[0] && trap_irq_q) begin
            vec_target = vec_target + (XLEN'(irq_cause(trap_idx_q)) << 2);
        end
    end

    assign flushing = (state_q == StEnter) || (state_q == StReturn);

    always_comb begin
        pc_dout_o = '0;
        if (state_q == StEnter) begin
            pc_dout_o = vec_target;
        end else if (state_q == StReturn) begin
            pc_dout_o = mepc;
        end
    end

    assign pc_wen_o       = flushing;
    assign npc_mux_sel_o  = flushing;
    assign if_id_clear_o  = flushing;
    assign id_ex_clear_o  = flushing;
    assign ex_mem_clear_o = flushing;
    assign trap_active_o  = state_q != StIdle;
    assign irq_ack_o      = irq_ack;

    trap_csr_file #(
        .XLEN       (XLEN),
        .N_IRQ      (N_IRQ),
        .TVEC_RESET (TVEC_RESET)
    ) u_csr (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .csr_wen_i      (csr_wen_i),
        .csr_wadd_i     (csr_wadd_i),
        .csr_din_i      (csr_din_i),
        .csr_radd_i     (csr_radd_i),
        .csr_dout_o     (csr_dout_o),
        .mip_i          (mip_q),
        .entry_i        (entry),
        .entry_mepc_i   (entry_mepc),
        .entry_mcause_i (entry_mcause),
        .entry_mtval_i  (entry_mtval),
        .mret_i         (mret_take),
        .df_set_i       (df_set),
        .mstatus_mie_o  (mstatus_mie),
        .mie_o          (mie_reg),
        .mtvec_o        (mtvec),
        .mepc_o         (mepc)
    );

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed plus randomized bench for trap_ctrl against a rule-level CSR/trap model.
module tb_trap_ctrl;
    import trap_pkg::*;

    localparam int F = 3;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [7:0]  irq_src, irq_ack;
    logic        exc_valid;
    logic [3:0]  exc_code;
    logic [31:0] exc_pc, exc_tval, id_pc;
    logic        mret;
    logic        csr_wen;
    logic [11:0] csr_wadd, csr_radd;
    logic [31:0] csr_din, csr_dout, pc_dout;
    logic        pc_wen, npc_sel, if_clr, id_clr, ex_clr, trap_active;

    int n_chk = 0;
    int n_pass = 0;

    // Reference model state
    logic        m_mie_b, m_mpie, m_df;
    logic [7:0]  m_mie, m_mip;
    logic [31:0] m_mtvec, m_mepc, m_mcause, m_mtval;

    always #10 clk = ~clk;

    trap_ctrl #(
        .XLEN         (32),
        .N_IRQ        (8),
        .TVEC_RESET   (32'h0000_F000),
        .FLUSH_CYCLES (F)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .irq_src_i      (irq_src),
        .irq_ack_o      (irq_ack),
        .exc_valid_i    (exc_valid),
        .exc_code_i     (exc_code),
        .exc_pc_i       (exc_pc),
        .exc_tval_i     (exc_tval),
        .id_pc_i        (id_pc),
        .mret_i         (mret),
        .csr_wen_i      (csr_wen),
        .csr_wadd_i     (csr_wadd),
        .csr_din_i      (csr_din),
        .csr_radd_i     (csr_radd),
        .csr_dout_o     (csr_dout),
        .pc_dout_o      (pc_dout),
        .pc_wen_o       (pc_wen),
        .npc_mux_sel_o  (npc_sel),
        .if_id_clear_o  (if_clr),
        .id_ex_clear_o  (id_clr),
        .ex_mem_clear_o (ex_clr),
        .trap_active_o  (trap_active)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] m_mstatus();
        return {23'b0, m_df, m_mpie, 3'b0, m_mie_b, 3'b0};
    endfunction

    function automatic logic [31:0] m_target(input logic is_irq, input int idx);
        logic [31:0] t;
        t = m_mtvec & ~32'h3;
        if (m_mtvec[0] && is_irq) t = t + 32'(4 * (16 + idx));
        return t;
    endfunction

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_mie_b = 0; m_mpie = 0; m_df = 0;
        m_mie = 0; m_mip = 0;
        m_mtvec = 32'h0000_F000; m_mepc = 0; m_mcause = 0; m_mtval = 0;
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] d);
        csr_radd = a;
        #1;
        d = csr_dout;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        csr_wen = 1; csr_wadd = a; csr_din = d;
        step();
        csr_wen = 0;
        case (a)
            CsrMstatus: begin m_mie_b = d[3]; m_mpie = d[7]; m_df = d[8]; end
            CsrMie:     m_mie = d[7:0];
            CsrMtvec:   m_mtvec = d;
            CsrMepc:    m_mepc = d;
            CsrMcause:  m_mcause = d;
            CsrMtval:   m_mtval = d;
            default:    ;
        endcase
    endtask

    task automatic check_csrs(input string tag);
        logic [31:0] d;
        rd(CsrMstatus, d); chk({tag, ".mstatus"}, d, m_mstatus());
        rd(CsrMie, d);     chk({tag, ".mie"}, d, {24'b0, m_mie});
        rd(CsrMtvec, d);   chk({tag, ".mtvec"}, d, m_mtvec);
        rd(CsrMepc, d);    chk({tag, ".mepc"}, d, m_mepc);
        rd(CsrMcause, d);  chk({tag, ".mcause"}, d, m_mcause);
        rd(CsrMtval, d);   chk({tag, ".mtval"}, d, m_mtval);
        rd(CsrMip, d);     chk({tag, ".mip"}, d, {24'b0, m_mip});
    endtask

    task automatic model_enter(input logic is_irq, input int idx, input logic [3:0] code,
                               input logic [31:0] pc, input logic [31:0] tval);
        m_mepc   = pc;
        m_mcause = is_irq ? (32'h8000_0000 | 32'(16 + idx)) : {28'b0, code};
        m_mtval  = is_irq ? 32'h0 : tval;
        m_mpie   = m_mie_b;
        m_mie_b  = 0;
        if (is_irq) m_mip[idx] = 1'b0;
    endtask

    task automatic model_mret();
        m_mie_b = m_mpie;
        m_mpie  = 1;
    endtask

    task automatic flush(input string tag, input logic [31:0] tgt);
        for (int k = 0; k < F; k++) begin
            chk({tag, ".ctl"}, {26'b0, pc_wen, npc_sel, if_clr, id_clr, ex_clr, trap_active},
                32'h3f);
            chk({tag, ".pc"}, pc_dout, tgt);
            chk({tag, ".ack"}, {24'b0, irq_ack}, 32'h0);
            step();
        end
        chk({tag, ".done"}, {31'b0, pc_wen}, 32'h0);
    endtask

    // Called in the IDLE cycle where the lowest enabled pending irq must be acked.
    task automatic service(input string tag);
        int idx;
        logic [31:0] tgt;
        idx = lowest(m_mip & m_mie);
        chk({tag, ".ack"}, {24'b0, irq_ack}, 32'(1) << idx);
        model_enter(1, idx, 4'h0, id_pc, 32'h0);
        tgt = m_target(1, idx);
        step();
        flush({tag, ".enter"}, tgt);
        chk({tag, ".active"}, {31'b0, trap_active}, 32'h1);
        check_csrs(tag);
        mret = 1;
        step();
        mret = 0;
        model_mret();
        flush({tag, ".ret"}, m_mepc);
    endtask

    initial begin
        logic [31:0] d, tgt;
        logic [7:0]  s;

        rst_ni = 0; irq_src = 0; exc_valid = 0; exc_code = 0; exc_pc = 0; exc_tval = 0;
        id_pc = 0; mret = 0; csr_wen = 0; csr_wadd = 0; csr_din = 0; csr_radd = 0;
        model_reset();
        step(); step(); step();
        rst_ni = 1;
        step();

        // Reset state
        chk("rst.outs", {18'b0, irq_ack, pc_wen, npc_sel, if_clr, id_clr, ex_clr, trap_active},
            32'h0);
        chk("rst.pc", pc_dout, 32'h0);
        rd(CsrMtvec, d);   chk("rst.mtvec_const", d, 32'h0000_F000);
        rd(CsrMstatus, d); chk("rst.mstatus_const", d, 32'h0);
        check_csrs("rst");

        // Direct-mode interrupt on source 2
        wr(CsrMstatus, 32'h8);
        wr(CsrMie, 32'h4);
        id_pc = $urandom & ~32'h3;
        irq_src = 8'h04;
        step();
        irq_src = 0;
        m_mip[2] = 1;
        chk("irq2.mcause_rule", 32'h8000_0000 | 32'(16 + 2), 32'h8000_0012);
        service("irq2");
        chk("irq2.idle", {30'b0, trap_active, pc_wen}, 32'h0);
        rd(CsrMstatus, d); chk("irq2.mie_restored", d, 32'h88);

        // Vectored mode, same source
        wr(CsrMtvec, 32'h0000_F001);
        id_pc = $urandom & ~32'h3;
        irq_src = 8'h04;
        step();
        irq_src = 0;
        m_mip[2] = 1;
        chk("vec.target_rule", m_target(1, 2), 32'h0000_F048);
        service("vec");

        // Exception beats a concurrently rising irq0; irq0 stays pending
        wr(CsrMie, 32'h5);
        exc_valid = 1; exc_code = ExcDiv0;
        exc_pc = $urandom & ~32'h3; exc_tval = $urandom;
        irq_src = 8'h01;
        #1;
        chk("exc.ack", {24'b0, irq_ack}, 32'h0);
        model_enter(0, 0, ExcDiv0, exc_pc, exc_tval);
        m_mip[0] = 1;
        tgt = m_target(0, 0);
        step();
        exc_valid = 0;
        flush("exc.enter", tgt);
        check_csrs("exc");

        // Nested exception only sets DF
        exc_valid = 1; exc_code = ExcDecode; exc_pc = $urandom; exc_tval = $urandom;
        #1;
        chk("df.nored", {30'b0, pc_wen, npc_sel}, 32'h0);
        step();
        exc_valid = 0;
        m_df = 1;
        chk("df.nored2", {30'b0, trap_active, pc_wen}, 32'h2);
        check_csrs("df");

        // mret returns to the faulting PC, then pending irq0 is taken at once
        id_pc = $urandom & ~32'h3;
        mret = 1;
        step();
        mret = 0;
        model_mret();
        flush("exc.ret", m_mepc);
        service("irq0");
        chk("irq0.noack", {24'b0, irq_ack}, 32'h0);
        check_csrs("irq0.after");
        irq_src = 0;
        step();

        // DF cleared only by software; mip is read-only; unmapped reads return 0
        wr(CsrMstatus, 32'h8);
        check_csrs("dfclr");
        wr(CsrMip, 32'hFF);
        check_csrs("mip_ro");
        rd(12'h123, d); chk("unmapped", d, 32'h0);

        // Randomized rounds: multiple sources pend while MIE=0, then drain by priority
        for (int r = 0; r < 8; r++) begin
            wr(CsrMstatus, 32'h0);
            wr(CsrMtvec, ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1)));
            wr(CsrMie, 32'($urandom_range(1, 255)));
            id_pc = $urandom & ~32'h3;
            s = 8'($urandom_range(1, 255));
            irq_src = s;
            step();
            irq_src = 0;
            m_mip = m_mip | s;
            step();
            wr(CsrMstatus, 32'h8);
            while ((m_mip & m_mie) != 0) service($sformatf("rnd%0d", r));
            chk("rnd.idle_ack", {24'b0, irq_ack}, 32'h0);
            chk("rnd.idle_act", {31'b0, trap_active}, 32'h0);
            check_csrs("rnd.end");
        end

        // Reset during ENTER aborts the redirect
        exc_valid = 1; exc_code = ExcMem; exc_pc = $urandom; exc_tval = $urandom;
        step();
        exc_valid = 0;
        chk("rstmid.inenter", {31'b0, pc_wen}, 32'h1);
        rst_ni = 0;
        #1;
        chk("rstmid.outs", {18'b0, irq_ack, pc_wen, npc_sel, if_clr, id_clr, ex_clr, trap_active},
            32'h0);
        chk("rstmid.pc", pc_dout, 32'h0);
        step();
        chk("rstmid.outs2", {26'b0, pc_wen, npc_sel, if_clr, id_clr, ex_clr, trap_active},
            32'h0);
        rst_ni = 1;
        model_reset();
        step();
        chk("rstmid.pc2", pc_dout, 32'h0);
        check_csrs("rstmid");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
